// File: rtl/fir_filter_seq.sv
// Sequential FIR filter: one shared multiply-accumulate walks the taps per sample,
// then the sum is rounded, saturated and presented as a registered result pulse.
module fir_filter_seq #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int FRAC   = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DATA_W-1:0]  sample_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic                      coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]   coef_wr_addr,
  input  logic signed [COEF_W-1:0]  coef_wr_data,
  output logic signed [DATA_W-1:0]  y_out,
  output logic                      y_valid,
  output logic                      y_sat
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + AW;

  localparam logic [AW-1:0]        LAST_IDX = AW'(TAPS - 1);
  localparam logic signed [ACC_W:0] ROUND_K = (ACC_W + 1)'(1) << (FRAC - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

  // Addresses at or beyond TAPS are only reachable when TAPS is not a power of two.
  function automatic logic [(1 << AW)-1:0] addr_mask();
    logic [(1 << AW)-1:0] m;
    m = '0;
    for (int i = 0; i < (1 << AW); i++) m[i] = (i < TAPS);
    return m;
  endfunction

  localparam logic [(1 << AW)-1:0] ADDR_OK = addr_mask();

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  x_q [TAPS];
  logic signed [DATA_W-1:0]  x_d [TAPS];
  logic signed [COEF_W-1:0]  h_q [TAPS];
  logic signed [COEF_W-1:0]  h_d [TAPS];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic signed [DATA_W-1:0]  y_out_q, y_out_d;
  logic                      y_valid_q, y_valid_d;
  logic                      y_sat_q, y_sat_d;

  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W:0]     rnd_sum;
  logic signed [ACC_W:0]     rnd_shift;
  logic signed [DATA_W-1:0]  sat_val;
  logic                      clip;

  assign sample_ready = (state_q == S_IDLE);
  assign y_out        = y_out_q;
  assign y_valid      = y_valid_q;
  assign y_sat        = y_sat_q;

  always_comb begin
    prod      = PROD_W'(x_q[idx_q]) * PROD_W'(h_q[idx_q]);
    rnd_sum   = (ACC_W + 1)'(acc_q) + ROUND_K;
    rnd_shift = rnd_sum >>> FRAC;
    clip      = 1'b0;
    sat_val   = rnd_shift[DATA_W-1:0];
    if (rnd_shift > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
      clip    = 1'b1;
    end else if (rnd_shift < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
      clip    = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    h_d       = h_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    y_out_d   = y_out_q;
    y_valid_d = 1'b0;
    y_sat_d   = 1'b0;

    if (state_q == S_IDLE && coef_wr_en && ADDR_OK[coef_wr_addr]) begin
      h_d[coef_wr_addr] = coef_wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          x_d[0] = sample_in;
          for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        y_out_d   = sat_val;
        y_valid_d = 1'b1;
        y_sat_d   = clip;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        h_q[k] <= '0;
      end
      acc_q     <= '0;
      idx_q     <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      y_sat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      h_q       <= h_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      y_sat_q   <= y_sat_d;
    end
  end

endmodule

// File: doc/fir_filter_seq.md
FIR_FILTER_SEQ -- requirements
Module: fir_filter_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample and output width, signed two's complement.
REQ-002 SHALL have parameter COEF_W, default 16: coefficient width, signed two's complement.
REQ-003 SHALL have parameter TAPS, default 8: filter length; legal range 2..64, power of two not required.
REQ-004 SHALL have parameter FRAC, default 15: coefficient fractional bits; legal range 1..COEF_W-1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port sample_in, input, DATA_W bits: signed input sample.
REQ-008 SHALL have port sample_valid, input, 1 bit: sample_in is valid.
REQ-009 SHALL have port sample_ready, output, 1 bit: block can accept a sample.
REQ-010 SHALL have port coef_wr_en, input, 1 bit: coefficient write strobe.
REQ-011 SHALL have port coef_wr_addr, input, clog2(TAPS) bits: coefficient index.
REQ-012 SHALL have port coef_wr_data, input, COEF_W bits: signed coefficient value.
REQ-013 SHALL have port y_out, output, DATA_W bits: signed filtered result, registered.
REQ-014 SHALL have port y_valid, output, 1 bit: one-cycle pulse marking a new y_out.
REQ-015 SHALL have port y_sat, output, 1 bit: valid with y_valid; high when y_out was clipped.

Function
REQ-016 SHALL implement y[n] = sum over k=0..TAPS-1 of h[k]*x[n-k], using one time-multiplexed multiplier-accumulator.
REQ-017 SHALL use an FSM with three states:
  - IDLE: sample_ready=1.
  - MAC: TAPS cycles, one product per cycle.
  - DONE: one cycle.
REQ-018 SHALL accept a sample on any edge where IDLE && sample_valid. At that edge it shall:
  - shift the delay line, so x[0]=sample_in and x[k]=old x[k-1];
  - clear the accumulator and tap index;
  - go to MAC.
REQ-019 SHALL, in MAC, add x[idx]*h[idx] to the accumulator at each edge for idx=0..TAPS-1, then go to DONE after idx=TAPS-1.
REQ-020 SHALL, at the DONE edge, register the y_out, y_valid and y_sat results and go to IDLE:
  - y_out = sat(round(acc));
  - y_valid = 1;
  - y_sat = clip flag.
REQ-021 SHALL give a latency of TAPS+1 edges from the accept edge to the y_valid edge.
REQ-022 SHALL have sample_ready high during the same cycle y_valid is high, giving a minimum sample spacing of TAPS+2 cycles.
REQ-023 SHALL keep sample_ready low in MAC and DONE; sample_valid there is ignored, and the source holds its sample until accepted.
REQ-024 SHALL size the accumulator at DATA_W+COEF_W+clog2(TAPS) bits, so it never overflows.
REQ-025 SHALL round by adding 2^(FRAC-1) to acc, then arithmetic-shifting right by FRAC.
REQ-026 SHALL saturate the rounded value to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; y_sat=1 iff clipping occurred.
REQ-027 SHALL hold y_out between results; y_valid and y_sat shall be low in every cycle except the DONE-edge cycle.
REQ-028 SHALL write coefficients only in IDLE: coef_wr_en writes h[coef_wr_addr] at the edge.
REQ-029 SHALL drop coef_wr_en in MAC or DONE with no effect, so coefficients are stable for the whole computation.
REQ-030 SHALL ignore coefficient writes with coef_wr_addr >= TAPS.
REQ-031 SHALL, when a sample accept and a coefficient write occur on the same IDLE edge, apply both; the computation then uses the new coefficient.

Reset
REQ-032 SHALL, while rst=0 (asynchronous), clear the following:
  - delay line to 0;
  - all h[k] to 0;
  - accumulator and index to 0;
  - FSM to IDLE;
  - y_out, y_valid and y_sat to 0.
REQ-033 SHALL set sample_ready=1 while rst=0 only through the IDLE state, and shall accept no sample while rst=0.
REQ-034 SHALL, on reset asserted mid-MAC, abort the computation: no y_valid, and state as in REQ-032 after release.

Verification (TAPS=4, DATA_W=COEF_W=16, FRAC=15)
REQ-035 SHALL check zero coefficients after reset: feed 0x7FFF, so y_valid fires 5 edges after accept with y_out=0 and y_sat=0.
REQ-036 SHALL check the impulse response:
  - stimulus: h={0x4000,0x2000,0x1000,0x0800}, then 0x7FFF,0,0,0 accepted as fast as ready allows;
  - required: y_out = 0x4000, 0x2000, 0x1000, 0x0800, with spacing 6 cycles.
REQ-037 SHALL check saturation:
  - stimulus: h[0]=h[1]=0x7FFF;
  - input 0x7FFF twice gives second y_out=0x7FFF, y_sat=1;
  - after 2 zero samples to flush, input 0x8000 twice gives second y_out=0x8000, y_sat=1.
REQ-038 SHALL check dropped writes: a coef_wr_en to h[0] pulsed during MAC is ignored, and the output is computed with old coefficients.
REQ-039 SHALL check backpressure: sample_valid held high continuously gives one accept per 6 cycles with sample_ready low in between, and no sample lost or duplicated.
REQ-040 SHALL check reset mid-operation: rst=0 for one cycle during MAC gives no y_valid, all outputs 0, and the next sample produces 0 output (coefficients cleared).
